// File: rtl/fir_pkg.sv
// Shared constants and decimation-select encoding for the FIR output decimator.
// The encoded value of decim_sel equals log2 of the decimation factor.
package fir_pkg;

    localparam int IN_W_DEF       = 16;
    localparam int OUT_W_DEF      = 8;
    localparam int FIFO_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        DECIM_1 = 2'd0,
        DECIM_2 = 2'd1,
        DECIM_4 = 2'd2,
        DECIM_8 = 2'd3
    } decim_e;

    // Sample index (0-based) of the last sample in a frame of the given factor.
    function automatic logic [2:0] decim_last_idx(input decim_e sel);
        case (sel)
            DECIM_1: return 3'd0;
            DECIM_2: return 3'd1;
            DECIM_4: return 3'd3;
            default: return 3'd7;
        endcase
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy output; a write when full is
// accepted only if a read happens on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rd_en,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_level;
    logic             w_rd;
    logic             w_wr;

    assign o_empty = (r_level == '0);
    assign o_full  = (r_level == (PTR_W+1)'(DEPTH));
    assign w_rd    = i_rd_en && !o_empty;
    assign w_wr    = i_wr_en && (!o_full || w_rd);

    // NOTE: storage has no reset; validity is tracked by the pointers and level.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_wr && !w_rd)      r_level <= r_level + (PTR_W+1)'(1);
            else if (w_rd && !w_wr) r_level <= r_level - (PTR_W+1)'(1);
        end
    end

    assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];
    assign o_level   = r_level;

endmodule

// File: rtl/fir_out_decimator.sv
// Decimates the FIR output stream: averages N samples, rounds, saturates and
// buffers the result in a small FIFO with a sticky overflow flag.
module fir_out_decimator
    import fir_pkg::*;
#(
    parameter int IN_W       = IN_W_DEF,
    parameter int OUT_W      = OUT_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IN_W-1:0]   y_in,
    input  logic              y_in_valid,
    input  logic [1:0]        decim_sel,
    input  logic [3:0]        shift,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        fifo_level,
    output logic              sat_flag,
    output logic              overflow
);

    localparam int ACC_W = IN_W + 3;
    localparam int SCL_W = IN_W + 4;
    localparam logic [SCL_W-1:0] SAT_MAX = SCL_W'((1 << OUT_W) - 1);

    logic [ACC_W-1:0]  r_acc;
    logic [2:0]        r_cnt;
    decim_e            r_sel;
    logic [ACC_W-1:0]  r_avg;
    logic [3:0]        r_avg_shift;
    logic              r_avg_vld;
    logic [OUT_W-1:0]  r_res;
    logic              r_res_sat;
    logic              r_res_vld;
    logic              r_overflow;

    decim_e            w_sel;
    logic [ACC_W-1:0]  w_acc_sum;
    logic              w_last;
    logic [SCL_W-1:0]  w_rounded;
    logic              w_sat;
    logic [OUT_W-1:0]  w_res;
    logic              w_empty;
    logic              w_full;
    logic              w_drop;
    logic [$clog2(FIFO_DEPTH):0] w_level;

    // The factor is taken from decim_sel only on the first sample of a frame.
    assign w_sel     = (r_cnt == 3'd0) ? decim_e'(decim_sel) : r_sel;
    assign w_acc_sum = r_acc + ACC_W'(y_in);
    assign w_last    = (r_cnt == decim_last_idx(w_sel));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_sel       <= DECIM_1;
            r_avg       <= '0;
            r_avg_shift <= '0;
            r_avg_vld   <= 1'b0;
        end else begin
            r_avg_vld <= 1'b0;
            if (y_in_valid) begin
                r_sel <= w_sel;
                if (w_last) begin
                    r_acc       <= '0;
                    r_cnt       <= '0;
                    r_avg       <= w_acc_sum >> w_sel;
                    r_avg_shift <= shift;
                    r_avg_vld   <= 1'b1;
                end else begin
                    r_acc <= w_acc_sum;
                    r_cnt <= r_cnt + 3'd1;
                end
            end
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_rounded = {1'b0, r_avg};
        if (r_avg_shift != 4'd0) begin
            w_rounded = ({1'b0, r_avg} + (SCL_W'(1) << (r_avg_shift - 4'd1))) >> r_avg_shift;
        end
        w_sat = (w_rounded > SAT_MAX);
        w_res = w_sat ? {OUT_W{1'b1}} : w_rounded[OUT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_res      <= '0;
            r_res_sat  <= 1'b0;
            r_res_vld  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_res_vld <= r_avg_vld;
            if (r_avg_vld) begin
                r_res     <= w_res;
                r_res_sat <= w_sat;
            end
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    // A full FIFO always presents valid data, so out_ready alone means a read.
    assign w_drop = r_res_vld && w_full && !out_ready;

    sync_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (r_res_vld),
        .i_wr_data (r_res),
        .i_rd_en   (out_ready),
        .o_rd_data (out_data),
        .o_empty   (w_empty),
        .o_full    (w_full),
        .o_level   (w_level)
    );

    assign out_valid  = !w_empty;
    assign fifo_level = 3'(w_level);
    assign sat_flag   = r_res_vld && r_res_sat && !w_drop;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_fir_out_decimator.sv
// Scoreboard bench: a queue-based reference model predicts every FIFO entry,
// a negedge monitor compares whatever the DUT presents.
module tb_fir_out_decimator;

    localparam int IN_W  = 16;
    localparam int OUT_W = 8;
    localparam int DEPTH = 4;
    localparam int MAXV  = (1 << OUT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [IN_W-1:0]  y_in = '0;
    logic             y_in_valid = 1'b0;
    logic [1:0]       decim_sel = 2'd0;
    logic [3:0]       shift = 4'd0;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [2:0]       fifo_level;
    logic             sat_flag;
    logic             overflow;

    int n_checks = 0;
    int n_fail   = 0;

    fir_out_decimator #(.IN_W(IN_W), .OUT_W(OUT_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .y_in       (y_in),
        .y_in_valid (y_in_valid),
        .decim_sel  (decim_sel),
        .shift      (shift),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_level (fifo_level),
        .sat_flag   (sat_flag),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { int due; int val; bit sat; } pend_t;
    pend_t pend_q[$];
    int    frame_q[$];
    int    exp_q[$];
    int    got_q[$];
    int    frame_n = 1;
    int    m_level = 0;
    bit    m_ovf = 1'b0;
    int    edge_no = 0;
    int    sat_seen = 0;

    always @(posedge clk) begin : model
        bit    rd;
        int    sum, avg, scaled;
        pend_t p;
        edge_no++;
        if (reset) begin
            pend_q.delete();
            frame_q.delete();
            exp_q.delete();
            m_level = 0;
            m_ovf   = 1'b0;
        end else begin
            rd = out_ready && (m_level > 0);
            if (pend_q.size() > 0 && pend_q[0].due == edge_no) begin
                p = pend_q.pop_front();
                if (m_level < DEPTH || rd) begin
                    exp_q.push_back(p.val);
                    m_level++;
                end else begin
                    m_ovf = 1'b1;
                end
            end
            if (rd) m_level--;
            if (y_in_valid) begin
                if (frame_q.size() == 0) frame_n = 1 << decim_sel;
                frame_q.push_back(int'(y_in));
                if (frame_q.size() == frame_n) begin
                    sum = 0;
                    foreach (frame_q[i]) sum += frame_q[i];
                    avg = sum / frame_n;
                    if (shift == 0) scaled = avg;
                    else scaled = (avg + (1 << (shift - 1))) / (1 << shift);
                    p.due = edge_no + 2;
                    p.sat = (scaled > MAXV);
                    p.val = p.sat ? MAXV : scaled;
                    pend_q.push_back(p);
                    frame_q.delete();
                end
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        int e;
        if (!reset) begin
            check("fifo_level", fifo_level, m_level);
            check("overflow", overflow, m_ovf);
            check("out_valid", out_valid, m_level != 0);
            if (sat_flag) sat_seen++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL out_unexpected: got %0d with empty scoreboard at %0t", out_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e);
                end
                got_q.push_back(int'(out_data));
            end else if (!out_valid) begin
                check("out_data_idle", out_data, 0);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int v);
        y_in = IN_W'(v);
        y_in_valid = 1'b1;
        cyc();
        y_in_valid = 1'b0;
    endtask

    task automatic check_seq(input string name, input int e[$]);
        check({name, "_count"}, got_q.size(), e.size());
        foreach (e[i]) begin
            if (i < got_q.size()) check({name, "_value"}, got_q[i], e[i]);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        y_in_valid = 1'b0;
        cyc(2);
        reset = 1'b0;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int e[$];
        int s0;
        do_reset();
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        check("reset_fifo_level", fifo_level, 0);
        check("reset_overflow", overflow, 0);
        check("reset_sat_flag", sat_flag, 0);

        // N=1, shift=0: saturation on 300
        got_q.delete(); s0 = sat_seen;
        decim_sel = 2'd0; shift = 4'd0; out_ready = 1'b1;
        send(10); send(20); send(300);
        cyc(5);
        e = '{10, 20, 255}; check_seq("n1_sat", e);
        check("n1_sat_pulses", sat_seen - s0, 1);

        // N=2: latency of first output
        got_q.delete();
        decim_sel = 2'd1;
        send(4); send(6);
        cyc();
        check("n2_valid_k1", out_valid, 0);
        cyc();
        check("n2_valid_k2", out_valid, 1);
        check("n2_first_data", out_data, 5);
        send(8); send(10);
        cyc(5);
        e = '{5, 9}; check_seq("n2", e);

        // N=1, shift=2: round half up
        got_q.delete();
        decim_sel = 2'd0; shift = 4'd2;
        send(22); send(21);
        cyc(5);
        e = '{6, 5}; check_seq("round", e);

        // Backpressure: overflow on a full FIFO
        got_q.delete();
        shift = 4'd0; out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) send(i);
        cyc(3);
        check("full_level", fifo_level, 4);
        check("full_overflow", overflow, 1);
        out_ready = 1'b1;
        cyc(6);
        e = '{1, 2, 3, 4}; check_seq("drain", e);
        check("overflow_sticky", overflow, 1);
        do_reset();
        cyc();
        check("overflow_cleared", overflow, 0);

        // Partial frame discarded by reset
        got_q.delete();
        decim_sel = 2'd2;
        send(100); send(100); send(100);
        do_reset();
        for (int i = 0; i < 4; i++) send(8);
        cyc(5);
        e = '{8}; check_seq("reset_frame", e);
        check("reset_frame_ovf", overflow, 0);

        // Full FIFO with a read on the write edge
        got_q.delete();
        decim_sel = 2'd0; out_ready = 1'b0;
        for (int i = 11; i <= 15; i++) send(i);
        cyc();
        check("rw_full_before", fifo_level, 4);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        check("rw_full_level", fifo_level, 4);
        check("rw_full_ovf", overflow, 0);
        out_ready = 1'b1;
        cyc(8);
        e = '{11, 12, 13, 14, 15}; check_seq("rw_full", e);

        // Randomised traffic, including mid-frame decim_sel changes and resets
        for (int c = 0; c < 1500; c++) begin
            y_in       = ($urandom_range(0, 3) == 0) ? IN_W'($urandom) : IN_W'($urandom_range(0, 700));
            y_in_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) decim_sel = 2'($urandom);
            shift      = 4'($urandom_range(0, 15));
            out_ready  = ($urandom_range(0, 2) != 0);
            reset      = ($urandom_range(0, 299) == 0);
            cyc();
        end
        reset = 1'b0; y_in_valid = 1'b0; out_ready = 1'b1;
        cyc(12);
        check("scoreboard_drained", exp_q.size(), 0);
        check("final_level", fifo_level, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
